fifo2axis: RTL and testbench



---
 rtl/fifo2axis.sv | 81 ++++++++
 tb/tb_fifo2axis.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo2axis.sv
// fifo2axis: pops wide FIFO words and unpacks each into MSB-first AXI4-Stream beats
//   M_AXIS_ACLK/M_AXIS_ARESET : clock, synchronous active-high reset
//   M_AXIS_T*                 : stream master (TSTRB constant all-ones, TLAST every PKT_BEATS beats)
//   frd_vld/frd_dat/frd_empty : FIFO pop request, read data one cycle after a pop, empty flag
//   frd_cnt                   : FIFO occupancy, informational only
//   busy                      : a pop is in flight or a word is held internally
module fifo2axis #(
  parameter int FAW = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int PKT_BEATS = 0
) (
  input  logic                         M_AXIS_ACLK,
  input  logic                         M_AXIS_ARESET,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                         M_AXIS_TLAST,
  output logic                         frd_vld,
  input  logic [AXI4_DATA_WIDTH-1:0]   frd_dat,
  input  logic                         frd_empty,
  input  logic [FAW:0]                 frd_cnt,
  output logic                         busy
);
  localparam int W = AXIS_DATA_WIDTH;
  localparam int N = AXI4_DATA_WIDTH / W;
  localparam int SW = $clog2(N);
  localparam int BW = PKT_BEATS > 1 ? $clog2(PKT_BEATS) : 1;
  localparam int LB = PKT_BEATS > 0 ? PKT_BEATS - 1 : 0;
  logic                       r_pend, r_pf_vld, r_buf_vld;
  logic [AXI4_DATA_WIDTH-1:0] r_pf_dat, r_buf_dat, w_shifted;
  logic [SW-1:0]              r_sub_cnt;
  logic [BW-1:0]              r_beat_cnt;
  logic                       w_fire, w_last_sub, w_buf_free, w_pf_take, w_bypass, w_unused;
  assign w_unused = ^frd_cnt;
  assign w_fire = r_buf_vld & M_AXIS_TREADY;
  assign w_last_sub = r_sub_cnt == SW'(N - 1);
  assign w_buf_free = !r_buf_vld | (w_fire & w_last_sub);
  assign w_pf_take = r_pf_vld & w_buf_free;
  // read data lands straight in the buffer only when nothing is queued ahead of it
  assign w_bypass = r_pend & w_buf_free & !r_pf_vld;
  // one pop in flight at most; a pop is allowed when the prefetch slot will be free to receive it
  assign frd_vld = !M_AXIS_ARESET & !frd_empty & !r_pend & (!r_pf_vld | w_pf_take);
  // sub_cnt 0 selects the most significant slice
  assign w_shifted = r_buf_dat << (W * r_sub_cnt);
  assign M_AXIS_TDATA = w_shifted[AXI4_DATA_WIDTH-1 -: W];
  assign M_AXIS_TVALID = r_buf_vld;
  assign M_AXIS_TSTRB = '1;
  assign M_AXIS_TLAST = r_buf_vld & (PKT_BEATS != 0) & (r_beat_cnt == BW'(LB));
  assign busy = r_pend | r_pf_vld | r_buf_vld;
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_pend <= 1'b0;
      r_pf_vld <= 1'b0;
      r_buf_vld <= 1'b0;
      r_pf_dat <= '0;
      r_buf_dat <= '0;
      r_sub_cnt <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_pend <= frd_vld;
      if (w_pf_take | w_bypass) begin
        r_buf_vld <= 1'b1;
        r_buf_dat <= w_pf_take ? r_pf_dat : frd_dat;
        r_sub_cnt <= '0;
      end else if (w_fire) begin
        r_buf_vld <= !w_last_sub;
        r_sub_cnt <= w_last_sub ? '0 : r_sub_cnt + 1'b1;
      end
      if (r_pend & !w_bypass) begin
        r_pf_vld <= 1'b1;
        r_pf_dat <= frd_dat;
      end else if (w_pf_take) begin
        r_pf_vld <= 1'b0;
      end
      if (w_fire & (PKT_BEATS != 0))
        r_beat_cnt <= (r_beat_cnt == BW'(LB)) ? '0 : r_beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo2axis.sv
// tb_fifo2axis: directed table, streaming, random backpressure and mid-stream reset checks
module tb_fifo2axis;
  localparam int N = 4;
  localparam int PKT = 6;
  logic clk = 1'b0, rst = 1'b1, tready = 1'b0;
  logic tvalid, tlast, tvalid0, tlast0, frd_vld, frd_vld0, busy, busy0, frd_empty;
  logic [31:0] tdata, tdata0;
  logic [3:0] tstrb, tstrb0;
  logic [127:0] frd_dat = '0;
  logic [8:0] frd_cnt;
  logic [127:0] mem [256];
  int wr_ptr = 0, rd_ptr = 0;
  int n_chk = 0, n_fail = 0, pops = 0, beat_idx = 0;
  logic [31:0] exp_q [$];
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo2axis #(.FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128), .PKT_BEATS(PKT)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast), .frd_vld(frd_vld),
    .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt), .busy(busy));

  fifo2axis #(.FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128), .PKT_BEATS(0)) dut0 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .M_AXIS_TVALID(tvalid0), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(tdata0), .M_AXIS_TSTRB(tstrb0), .M_AXIS_TLAST(tlast0), .frd_vld(frd_vld0),
    .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt), .busy(busy0));

  assign frd_empty = wr_ptr == rd_ptr;
  assign frd_cnt = 9'(wr_ptr - rd_ptr);

  always @(posedge clk)
    if (frd_vld && !frd_empty) begin
      frd_dat <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: every popped word contributes its four 32-bit slices MSB first; beats must follow that order
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      beat_idx = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(tvalid), 128'(1));
        chk("hold_data", 128'(tdata), 128'(prev_data));
        chk("hold_last", 128'(tlast), 128'(prev_last));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", tdata);
        end else begin
          chk("tdata", 128'(tdata), 128'(exp_q.pop_front()));
          chk("tlast", 128'(tlast), 128'(beat_idx % PKT == PKT - 1));
          chk("tlast_nopkt", 128'(tlast0), 128'(0));
          beat_idx++;
        end
      end
      if (frd_vld) begin
        chk("pop_nonempty", 128'(frd_empty), 128'(0));
        if (!frd_empty) begin
          pops++;
          for (int i = N - 1; i >= 0; i--) exp_q.push_back(mem[rd_ptr % 256][i*32 +: 32]);
        end
      end
      chk("held_words", 128'(exp_q.size() <= 2 * N), 128'(1));
      prev_stall = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
    end
  end

  typedef struct {
    logic rst;
    logic rdy;
    logic vld;
    logic tv;
    logic ck_td;
    logic [31:0] td;
    logic bsy;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int k, bubbles, p0, pushed;
    logic [127:0] w4;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00112233, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44556677, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8899AABB, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCCDDEEFF, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    repeat (2) @(negedge clk);
    push(128'h00112233_44556677_8899AABB_CCDDEEFF);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      rst = tbl[i].rst;
      tready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_frd_vld", i), 128'(frd_vld), 128'(tbl[i].vld));
      chk($sformatf("vec%0d_tvalid", i), 128'(tvalid), 128'(tbl[i].tv));
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(tbl[i].bsy));
      if (tbl[i].ck_td) chk($sformatf("vec%0d_tdata", i), 128'(tdata), 128'(tbl[i].td));
      if (tbl[i].rst) begin
        chk("reset_tlast", 128'(tlast), 128'(0));
        chk("reset_tstrb", 128'(tstrb), 128'(4'hF));
      end
    end
    @(negedge clk);
    p0 = pops;
    for (int i = 0; i < 64; i++) push(rnd());
    #1;
    k = 0;
    while (!tvalid && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("stream_start", 128'(tvalid), 128'(1));
    bubbles = 0;
    for (int i = 0; i < 256; i++) begin
      if (!tvalid) bubbles++;
      @(negedge clk);
      #1;
    end
    chk("stream_bubbles", 128'(bubbles), 128'(0));
    chk("stream_end", 128'(tvalid), 128'(0));
    chk("stream_pops", 128'(pops - p0), 128'(64));
    pushed = 0;
    k = 0;
    while (k < 4000 && !(pushed == 32 && exp_q.size() == 0 && frd_empty && !busy)) begin
      @(negedge clk);
      tready = 1'($urandom % 2);
      if (pushed < 32 && $urandom % 3 == 0) begin
        push(rnd());
        pushed++;
      end
      #2;
      k++;
    end
    chk("bp_drained", 128'(k < 4000), 128'(1));
    @(negedge clk);
    tready = 1'b1;
    push(rnd());
    #1;
    k = 0;
    while (!(dut.r_sub_cnt == 2'd1 && tvalid) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_setup_found", 128'(k < 20), 128'(1));
    @(negedge clk);
    tready = 1'b0;
    push(rnd());
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_setup_pend", 128'(dut.r_pend), 128'(1));
    chk("rst_setup_sub", 128'(dut.r_sub_cnt), 128'(2));
    @(negedge clk);
    rst = 1'b0;
    tready = 1'b1;
    w4 = rnd();
    push(w4);
    push(rnd());
    #1;
    chk("rst_tvalid", 128'(tvalid), 128'(0));
    chk("rst_tlast", 128'(tlast), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    k = 0;
    while (!tvalid && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_first_beat", 128'(tdata), 128'(w4[127:96]));
    k = 0;
    while (k < 100 && !(exp_q.size() == 0 && frd_empty && !busy)) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("rst_drained", 128'(k < 100), 128'(1));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
